cam_pattern_gen: RTL and testbench

CAM_PATTERN_GEN -- requirements
Module: cam_pattern_gen

---
 rtl/cam_pattern_gen.sv | 97 +++++++++
 tb/tb_cam_pattern_gen.sv | 134 +++++++++++++
 2 files changed

// File: rtl/cam_pattern_gen.sv
// cam_pattern_gen: camera timing generator with selectable test patterns.
// Produces line/frame syncs, pixel data and a completed-frame counter.
module cam_pattern_gen #(
    parameter int HEND   = 1567,
    parameter int HON    = 287,
    parameter int VEND   = 509,
    parameter int VPEND  = 2,
    parameter int HWIDTH = 11,
    parameter int VWIDTH = 9,
    parameter int CKLOG  = 5
) (
    input  logic       PCLK,
    input  logic       RST,
    input  logic       Enable,
    input  logic [1:0] Mode,
    output logic       CamHsync,
    output logic       CamVsync,
    output logic [7:0] CamData,
    output logic       FrameStart,
    output logic [7:0] FrameCnt,
    output logic       Busy
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    localparam int HX = (HWIDTH > 11) ? HWIDTH : 11;

    state_t              r_state, w_next;
    logic [HWIDTH-1:0]   r_h;
    logic [VWIDTH-1:0]   r_v;
    logic                r_hs, r_vs;
    logic [7:0]          r_fc;
    logic [1:0]          r_mode;
    logic                w_run, w_hend, w_fend;
    logic [HX-1:0]       w_hx;
    logic [7:0]          w_pix;

    assign w_run  = (r_state == RUN);
    assign w_hend = (r_h == HWIDTH'(HEND));
    assign w_fend = w_run && w_hend && (r_v == VWIDTH'(VEND));

    always_comb begin
        w_next = r_state;
        if (!w_run && Enable)
            w_next = RUN;
        else if (w_fend && !Enable)
            w_next = IDLE;
    end

    always_ff @(posedge PCLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_h     <= '0;
            r_v     <= '0;
            r_hs    <= 1'b0;
            r_vs    <= 1'b1;
            r_fc    <= '0;
            r_mode  <= '0;
        end else begin
            r_state <= w_next;
            if (!w_run) begin
                r_hs <= 1'b0;
                r_vs <= 1'b1;
                if (Enable)
                    r_mode <= Mode;
            end else begin
                r_h <= w_hend ? '0 : r_h + 1'b1;
                if (w_hend)
                    r_v <= (r_v == VWIDTH'(VEND)) ? '0 : r_v + 1'b1;
                if (r_h == HWIDTH'(HON))
                    r_hs <= 1'b1;
                else if (w_hend)
                    r_hs <= 1'b0;
                // Vsync edges are taken at line end so they align with line boundaries
                if (w_hend && r_v == VWIDTH'(VPEND))
                    r_vs <= 1'b0;
                else if (w_hend && r_v == VWIDTH'(VEND))
                    r_vs <= 1'b1;
                if (w_fend) begin
                    r_fc   <= r_fc + 1'b1;
                    r_mode <= Mode;
                end
            end
        end
    end

    assign w_hx  = HX'(r_h);
    assign w_pix = (r_mode == 2'd0) ? (w_hx[3] ? r_v[7:0] : {1'b0, w_hx[10:4]}) :
                   (r_mode == 2'd1) ? {r_h[HWIDTH-1 -: 3], 5'b0} :
                   (r_mode == 2'd2) ? ((w_hx[CKLOG] ^ r_v[CKLOG]) ? 8'hFF : 8'h00) :
                                      w_hx[7:0] + r_fc;

    assign CamHsync   = r_hs;
    assign CamVsync   = r_vs;
    assign CamData    = w_run ? w_pix : 8'h00;
    assign FrameStart = w_run && (r_h == '0) && (r_v == '0);
    assign FrameCnt   = r_fc;
    assign Busy       = w_run;
endmodule

// File: tb/tb_cam_pattern_gen.sv
// tb_cam_pattern_gen: directed checks of the pattern generator on a small raster.
// 66 pixels x 3 lines per frame keeps a full FrameCnt wrap short.
module tb_cam_pattern_gen;
    localparam int H = 65, HON = 3, VE = 2, VP = 1, HW = 9, VW = 8, CK = 2;

    logic       clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       hs, vs, fs, busy;
    logic [7:0] data, fc;
    int         n_chk = 0, n_fail = 0;
    int         bh = 0, bv = 0;

    cam_pattern_gen #(.HEND(H), .HON(HON), .VEND(VE), .VPEND(VP),
                      .HWIDTH(HW), .VWIDTH(VW), .CKLOG(CK)) dut (
        .PCLK(clk), .RST(rst), .Enable(en), .Mode(mode),
        .CamHsync(hs), .CamVsync(vs), .CamData(data),
        .FrameStart(fs), .FrameCnt(fc), .Busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step;
        @(posedge clk);
        bh = (bh == H) ? 0 : bh + 1;
        if (bh == 0)
            bv = (bv == VE) ? 0 : bv + 1;
        @(negedge clk);
    endtask

    task automatic go(input int h, input int v);
        do step(); while (!(bh == h && bv == v));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_hs", hs, 0);
        check("rst_vs", vs, 1);
        check("rst_data", data, 0);
        check("rst_fs", fs, 0);
        check("rst_fc", fc, 0);

        rst = 1'b0; en = 1'b1;
        tick(); bh = 0; bv = 0;
        check("start_fs", fs, 1);
        check("start_busy", busy, 1);
        check("start_data", data, 0);
        check("start_vs", vs, 1);
        go(1, 0);  check("fs_low", fs, 0);
        go(3, 0);  check("hs_before", hs, 0);
        go(4, 0);  check("hs_rise", hs, 1);
        go(8, 0);  check("m0_h8v0", data, 0);
        go(16, 0); check("m0_h16", data, 8'h01);
        go(65, 0); check("hs_lineend", hs, 1);
        go(0, 1);  check("hs_wrap", hs, 0);
        check("fs_line1", fs, 0);
        go(8, 1);  check("m0_h8v1", data, 8'h01);
        go(65, 1); check("vs_before_fall", vs, 1);
        go(0, 2);  check("vs_fall", vs, 0);
        go(24, 2); check("m0_h24v2", data, 8'h02);
        go(32, 2); check("m0_h32v2", data, 8'h02);
        go(65, 2); check("vs_low_end", vs, 0);
        go(0, 0);  check("vs_rise", vs, 1);
        check("fc_1", fc, 1);
        check("fs_frame1", fs, 1);

        mode = 2'd1;
        go(16, 0); check("midframe_mode", data, 8'h01);
        go(0, 0);  check("fc_2", fc, 2);
        check("m1_h0", data, 0);
        go(64, 0); check("m1_h64", data, 8'h20);
        mode = 2'd2;
        go(65, 1); check("m1_hold", data, 8'h20);
        go(0, 0);  check("m2_h0", data, 8'h00);
        go(4, 0);  check("m2_h4", data, 8'hFF);
        go(8, 0);  check("m2_h8", data, 8'h00);
        go(5, 1);  check("m2_h5v1", data, 8'hFF);
        mode = 2'd3;
        go(0, 0);  check("fc_4", fc, 4);
        go(10, 0); check("m3_h10", data, 8'h0E);

        repeat (251) go(0, 0);
        check("fc_255", fc, 255);
        go(1, 0);  check("m3_wrap", data, 8'h00);
        go(65, 0); check("m3_h65", data, 8'h40);
        go(0, 0);  check("fc_wrap", fc, 0);
        check("m3_fc0", data, 0);

        go(0, 1); en = 1'b0;
        go(65, 2); check("busy_to_end", busy, 1);
        tick();
        check("idle_busy", busy, 0);
        check("idle_hs", hs, 0);
        check("idle_vs", vs, 1);
        check("idle_data", data, 0);
        check("idle_fs", fs, 0);
        check("idle_fc", fc, 1);
        repeat (5) tick();
        check("idle_stay", busy, 0);

        en = 1'b1;
        tick(); bh = 0; bv = 0;
        check("restart_fs", fs, 1);
        check("restart_data", data, 8'h01);
        go(10, 1); rst = 1'b1;
        tick();
        check("mrst_busy", busy, 0);
        check("mrst_fc", fc, 0);
        check("mrst_vs", vs, 1);
        check("mrst_hs", hs, 0);
        rst = 1'b0;
        tick();
        check("rerun_busy", busy, 1);
        check("rerun_fs", fs, 1);
        check("rerun_data", data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
